// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and counter width helper
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Counter width able to hold max_val without wrapping
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - reset request inputs and reset/status outputs
interface reset_sequencer_if #(
  parameter int NUM_LOCKS   = 2,
  parameter int NUM_OUTPUTS = 3
);
  logic                   btn_in;
  logic [NUM_LOCKS-1:0]   locks_in;
  logic [NUM_OUTPUTS-1:0] rst_out;
  logic                   ready;
  logic [NUM_LOCKS:0]     cause;

  modport master (
    input  btn_in, locks_in,
    output rst_out, ready, cause
  );

  modport slave (
    output btn_in, locks_in,
    input  rst_out, ready, cause
  );
endinterface

// File: rtl/reset_sequencer_sync_debounce.sv
// rtl/reset_sequencer_sync_debounce.sv - async input synchroniser with optional debounce
module sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit DEBOUNCE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   db_q;
  logic [CW-1:0]          cnt_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else if (sync_s == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_q  <= sync_s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Lock inputs take the synchroniser output directly
  assign dout = DEBOUNCE_EN ? db_q : sync_s;
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - lock/button driven reset generator with staggered release
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_LOCKS       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 16,
  parameter int NUM_OUTPUTS     = 3,
  parameter int STAGGER_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reset_sequencer_if.master    bus
);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int SW = cnt_width(STAGGER_CYCLES);
  localparam int IW = cnt_width(NUM_OUTPUTS);

  logic                   btn_db;
  logic [NUM_LOCKS-1:0]   lk_s;
  logic                   healthy;

  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [SW-1:0]          stag_q, stag_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic [NUM_LOCKS:0]     cause_q, cause_d;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEBOUNCE_EN     (1'b1)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.btn_in),
    .dout (btn_db)
  );

  for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_lock
    sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (1),
      .DEBOUNCE_EN     (1'b0)
    ) u_lock (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.locks_in[g]),
      .dout (lk_s[g])
    );
  end

  assign healthy = (&lk_s) & ~btn_db;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ASSERT;
      hold_q    <= '0;
      stag_q    <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      stag_q    <= stag_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state: any fault collapses to ASSERT at once; release is staggered
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stag_d    = stag_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    cause_d   = cause_q;

    if (state_q != ASSERT && !healthy) begin
      state_d   = ASSERT;
      rst_out_d = '1;
      ready_d   = 1'b0;
      hold_d    = '0;
      stag_d    = '0;
      idx_d     = '0;
      cause_d   = {btn_db, ~lk_s};
    end else begin
      case (state_q)
        ASSERT: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (healthy) begin
            state_d = HOLD;
            hold_d  = '0;
            stag_d  = '0;
            idx_d   = '0;
          end
        end
        HOLD: begin
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            hold_d       = '0;
            rst_out_d[0] = 1'b0;
            if (NUM_OUTPUTS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IW'(1);
              stag_d  = '0;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RELEASE: begin
          if (stag_q == SW'(STAGGER_CYCLES - 1)) begin
            stag_d = '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
              if (idx_q == IW'(i)) rst_out_d[i] = 1'b0;
            end
            if (idx_q == IW'(NUM_OUTPUTS - 1)) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            stag_d = stag_q + SW'(1);
          end
        end
        RUN: begin
          ready_d = 1'b1;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;
  assign bus.cause   = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed vector bench for reset_sequencer
module tb_reset_sequencer;

  typedef struct {
    int         rel;
    logic [2:0] rst_out;
    logic       ready;
    logic [2:0] cause;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   failed;
  vec_t vq[$];

  reset_sequencer_if #(.NUM_LOCKS(2), .NUM_OUTPUTS(3)) bus1 ();
  reset_sequencer_if #(.NUM_LOCKS(4), .NUM_OUTPUTS(1)) bus2 ();

  reset_sequencer #(
    .NUM_LOCKS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES(16), .NUM_OUTPUTS(3), .STAGGER_CYCLES(4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  reset_sequencer #(
    .NUM_LOCKS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES(1), .NUM_OUTPUTS(1), .STAGGER_CYCLES(1)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input int rel, input logic [2:0] r, input logic rdy, input logic [2:0] c);
    vec_t v;
    v.rel = rel; v.rst_out = r; v.ready = rdy; v.cause = c;
    vq.push_back(v);
  endtask

  task automatic run_vec(input string tag, input int base);
    for (int i = 0; i < vq.size(); i++) begin
      while (cyc < base + vq[i].rel) tick();
      check($sformatf("%s rst_out +%0d", tag, vq[i].rel), 32'(bus1.rst_out), 32'(vq[i].rst_out));
      check($sformatf("%s ready +%0d", tag, vq[i].rel), 32'(bus1.ready), 32'(vq[i].ready));
      check($sformatf("%s cause +%0d", tag, vq[i].rel), 32'(bus1.cause), 32'(vq[i].cause));
    end
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, p, r;
    tests = 0; failed = 0; cyc = 0;
    rst = 1'b0;
    bus1.btn_in = 1'b0; bus1.locks_in = 2'b11;
    bus2.btn_in = 1'b0; bus2.locks_in = 4'hF;
    #1 rst = 1'b1;
    #1;
    check("reset rst_out", 32'(bus1.rst_out), 32'h7);
    check("reset ready", 32'(bus1.ready), 32'h0);
    check("reset cause", 32'(bus1.cause), 32'h0);
    #1 rst = 1'b0;

    // Power-up release sequence
    add(2, 3'b111, 1'b0, 3'b000);
    add(18, 3'b111, 1'b0, 3'b000);
    add(19, 3'b110, 1'b0, 3'b000);
    add(22, 3'b110, 1'b0, 3'b000);
    add(23, 3'b100, 1'b0, 3'b000);
    add(26, 3'b100, 1'b0, 3'b000);
    add(27, 3'b000, 1'b1, 3'b000);
    add(30, 3'b000, 1'b1, 3'b000);
    run_vec("powerup", 0);

    // One-cycle loss of lock 1 while running
    e = cyc;
    bus1.locks_in = 2'b01;
    tick();
    bus1.locks_in = 2'b11;
    add(2, 3'b000, 1'b1, 3'b000);
    add(3, 3'b111, 1'b0, 3'b010);
    add(4, 3'b111, 1'b0, 3'b010);
    add(19, 3'b111, 1'b0, 3'b010);
    add(20, 3'b110, 1'b0, 3'b010);
    add(24, 3'b100, 1'b0, 3'b010);
    add(27, 3'b100, 1'b0, 3'b010);
    add(28, 3'b000, 1'b1, 3'b010);
    run_vec("lockloss", e);

    // Short button glitch is filtered
    bus1.btn_in = 1'b1;
    repeat (10) tick();
    bus1.btn_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("glitch out %0d", i), 32'({bus1.rst_out, bus1.ready}), 32'h1);
    end

    // Long button press, then debounced release restarts the sequence
    p = cyc;
    bus1.btn_in = 1'b1;
    add(18, 3'b000, 1'b1, 3'b010);
    add(19, 3'b111, 1'b0, 3'b100);
    run_vec("press", p);
    while (cyc < p + 40) tick();
    bus1.btn_in = 1'b0;
    add(58, 3'b111, 1'b0, 3'b100);
    add(74, 3'b111, 1'b0, 3'b100);
    add(75, 3'b110, 1'b0, 3'b100);
    add(79, 3'b100, 1'b0, 3'b100);
    run_vec("btnrel", p);

    // Lock 0 lost after two lines released: all re-assert together
    e = cyc;
    bus1.locks_in = 2'b10;
    add(2, 3'b100, 1'b0, 3'b100);
    add(3, 3'b111, 1'b0, 3'b001);
    run_vec("midrel", e);
    bus1.locks_in = 2'b11;
    add(21, 3'b111, 1'b0, 3'b001);
    add(22, 3'b110, 1'b0, 3'b001);
    add(26, 3'b100, 1'b0, 3'b001);
    add(30, 3'b000, 1'b1, 3'b001);
    run_vec("midrec", e);

    // Asynchronous reset between edges takes effect immediately
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst_out", 32'(bus1.rst_out), 32'h7);
    check("async ready", 32'(bus1.ready), 32'h0);
    check("async cause", 32'(bus1.cause), 32'h0);
    tick();
    r = cyc;
    rst = 1'b0;

    // Single-output instance: release and ready on the edge HOLD ends
    while (cyc < r + 3) tick();
    check("p1 hold rst_out", 32'(bus2.rst_out), 32'h1);
    check("p1 hold ready", 32'(bus2.ready), 32'h0);
    tick();
    check("p1 run rst_out", 32'(bus2.rst_out), 32'h0);
    check("p1 run ready", 32'(bus2.ready), 32'h1);
    check("p1 run cause", 32'(bus2.cause), 32'h0);
    repeat (2) tick();
    e = cyc;
    bus2.locks_in = 4'b0111;
    tick();
    bus2.locks_in = 4'hF;
    tick();
    check("p1 drop+2 rst_out", 32'(bus2.rst_out), 32'h0);
    tick();
    check("p1 drop+3 rst_out", 32'(bus2.rst_out), 32'h1);
    check("p1 drop+3 ready", 32'(bus2.ready), 32'h0);
    check("p1 drop+3 cause", 32'(bus2.cause), 32'h08);
    tick();
    check("p1 drop+4 rst_out", 32'(bus2.rst_out), 32'h1);
    tick();
    check("p1 drop+5 rst_out", 32'(bus2.rst_out), 32'h0);
    check("p1 drop+5 ready", 32'(bus2.ready), 32'h1);
    check("p1 drop+5 elapsed", 32'(cyc - e), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset generator for the CPU and peripheral clock domain. It synchronises N asynchronous lock inputs (PLL, IDELAYCTRL, future MMCMs) and a debounced push-button. It holds all downstream resets for a programmable stretch, then releases NUM_OUTPUTS reset lines in staggered order. It also records the cause of the most recent reset and replaces the ad-hoc reset counter logic in the top level.

Parameters:
NUM_LOCKS, 2, number of asynchronous active-high lock/ready inputs
SYNC_STAGES, 2, flop stages per async input synchroniser (min 2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to change the debounced button value (min 1)
HOLD_CYCLES, 16, cycles all sources must stay healthy before release begins (min 1)
NUM_OUTPUTS, 3, number of reset outputs; index 0 releases first
STAGGER_CYCLES, 4, cycles between successive output releases (min 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset of this block
btn_in  in  1  raw asynchronous push-button, active-high = reset request
locks_in  in  NUM_LOCKS  asynchronous lock signals, all must be 1 to run
rst_out  out  NUM_OUTPUTS  registered active-high resets to downstream logic
ready  out  1  registered; 1 once every rst_out is released
cause  out  NUM_LOCKS+1  sticky cause of last reset: bit NUM_LOCKS = button, bits [NUM_LOCKS-1:0] = lock lost

Behaviour:
- rst asserted (async): rst_out = all ones, ready = 0, cause = 0, synchronisers = 0, btn_db = 0, state = ASSERT, counters = 0.
- Synchroniser: each locks_in bit and btn_in passes through SYNC_STAGES flops → lk_s, btn_s.
- Debounce: cnt counts cycles where btn_s != btn_db. Any cycle with btn_s == btn_db clears cnt. After DEBOUNCE_CYCLES consecutive differing cycles, btn_db <= btn_s and cnt <= 0.
- healthy = (&lk_s) & ~btn_db.
- FSM states: ASSERT, HOLD, RELEASE, RUN.
- ASSERT: rst_out all ones. If healthy, go to HOLD with hold counter = 0.
- HOLD: counter increments each cycle. The edge ending the HOLD_CYCLES-th cycle enters RELEASE and drives rst_out[0] low on that same edge.
- RELEASE: rst_out[i] goes low exactly i*STAGGER_CYCLES cycles after rst_out[0]. Released lines stay low. On the edge rst_out[NUM_OUTPUTS-1] goes low, ready goes to 1 and state goes to RUN. With NUM_OUTPUTS=1, HOLD goes straight to RUN.
- RUN: outputs held; ready = 1.
- Unhealthy in HOLD, RELEASE or RUN: on the next edge go to ASSERT, all rst_out = 1, ready = 0, counters cleared. Already-released lines re-assert together; there is no reverse staggering.
- cause: on each transition into ASSERT from a non-ASSERT state, latch {btn_db, ~lk_s}. Otherwise hold. Simultaneous button and lock loss sets both bits.
- Latency, lock drop to rst_out high: SYNC_STAGES+1 edges.
- Latency, button press to rst_out high: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
- Button glitches shorter than DEBOUNCE_CYCLES have no effect.
- Holding the button keeps the FSM in ASSERT. The release sequence starts only after debounced release.
- Locks chattering during HOLD restart HOLD from 0 each time via ASSERT.
- Counter widths are $clog2 of their max value plus 1; counters never wrap.

Decomposition:
- Shared package: state encoding (ASSERT=2'd0, HOLD=2'd1, RELEASE=2'd2, RUN=2'd3) and a width helper for counters.
- One sub-module, sync_debounce (async input → SYNC_STAGES synchroniser + DEBOUNCE counter). Instantiated once for the button. Lock bits use the synchroniser-only path (debounce bypass parameter = 0).

Test Plan:
- Power-up: locks_in=2'b11, btn_in=0, rst released before edge 1 → FSM enters HOLD at edge 3. rst_out[0] falls at edge 19, rst_out[1] at 23, rst_out[2] at 27. ready=1 at 27. cause=0.
- Lock loss in RUN: drop locks_in[1] for 1 cycle → rst_out=3'b111, ready=0 at SYNC_STAGES+1 = 3 edges later. cause=3'b010. Full release sequence restarts: 16 hold cycles + 8 stagger cycles.
- Button glitch: btn_in high for 10 cycles in RUN → no change on rst_out/ready. Held for 40 cycles → rst_out all 1 at edge 2+16+1 = 19 after press. cause=3'b100. Release sequence starts after the debounced release.
- Mid-release fault: drop locks_in[0] after rst_out[0] and rst_out[1] are released → all lines re-assert together. cause=3'b001. No staggered re-assert.
- Async rst mid-RUN: assert rst between edges → rst_out=3'b111, ready=0, cause=0 immediately, before the next edge.
- Parameter sweep: NUM_OUTPUTS=1, STAGGER_CYCLES=1, HOLD_CYCLES=1, NUM_LOCKS=4 → single output falls the edge after HOLD ends. ready rises on the same edge.
